cache_fill_server: RTL and testbench
====================================

# cache_fill_server

Memory-side responder for the block cache. It serves whole-block requests: block fills (read) and block write-backs (write). Each request is turned into a burst of single-word accesses on a word-wide synchronous RAM. Sits between the cache's block port and data memory, so the cache sees one wide request/response per block.

## Interface

Parameters:
- DATA_WIDTH, 32, bits per word
- ADDRESS_WIDTH, 30, word-address width
- BLOCK_SIZE, 3, log2 of words per block (S = 2**BLOCK_SIZE; JUST_DATA = DATA_WIDTH*S)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  block request present
- req_ready  out  1  block can accept a request (1 only in IDLE)
- req_write  in  1  1 = write-back, 0 = fill
- req_addr  in  ADDRESS_WIDTH  word address; low BLOCK_SIZE bits ignored
- req_wdata  in  JUST_DATA  block to write; word k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  JUST_DATA  filled block (read) or echoed written block (write); same word packing
- mem_addr  out  ADDRESS_WIDTH  RAM word address
- mem_we  out  1  RAM write strobe
- mem_wr_data  out  DATA_WIDTH  RAM write word
- mem_rd_data  in  DATA_WIDTH  RAM read word; valid one cycle after its address (synchronous read)

## Operation

- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_data 0, mem_addr 0, mem_we 0, mem_wr_data 0, word counter 0.
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - Handshake fires on the edge where req_valid && req_ready.
  - On that edge, latch base = {req_addr[ADDRESS_WIDTH-1:BLOCK_SIZE], BLOCK_SIZE'b0} and req_write.
  - On a write, also latch req_wdata.
  - Go to WRITE if req_write, else READ.
  - req_valid while not in IDLE is ignored; there is no queueing.
- READ:
  - Issue cycles k = 0..S-1 drive mem_addr = base + k with mem_we = 0.
  - The word returned in the cycle after issue k is stored into resp_data word k.
  - One extra drain cycle after issue S-1 captures word S-1.
  - Then go to RESP.
  - resp_data words update progressively during the burst. They are stable and complete when resp_valid is 1.
- WRITE:
  - Cycles k = 0..S-1: mem_we = 1, mem_addr = base + k, mem_wr_data = latched word k.
  - Then go to RESP. resp_data takes the latched block.
- RESP:
  - resp_valid = 1 for exactly one cycle, then go to IDLE.
  - resp_data holds its value until the next accepted request modifies it.
- Address arithmetic: base is block-aligned, so base + k never carries into the tag/set bits. The topmost block (all ones above the offset) needs no wrap handling.
- Outside READ/WRITE issue cycles, mem_addr = 0 and mem_we = 0.
- Reset mid-burst:
  - Abort immediately; outputs return to reset values asynchronously, including mem_we dropping at once.
  - No resp_valid is produced.
  - RAM words already written by an aborted write-back remain written.

## Timing

- Accept edge = edge 0.
- Read: issue cycles 1..S; capture edges 2..S+1; resp_valid high in cycle S+2 (cycle 10 for S = 8). Request-to-response latency is S+2 cycles.
- Write: mem_we high in cycles 1..S; resp_valid high in cycle S+1 (cycle 9 for S = 8).
- req_ready is low from cycle 1 through the RESP cycle. It is high again in the cycle after RESP, so the minimum spacing between accepted requests is S+3 (read) or S+2 (write) cycles.
- resp_valid, req_ready, mem_addr and mem_we are decoded from registered state/counter only. There is no combinational path from req_* inputs to any output.

## Test plan

- Reset then idle: assert rst asynchronously mid-cycle -> all outputs at reset values immediately; req_ready = 1 after release.
- Fill:
  - Preload RAM words 0x40..0x47 with 0xA0+k.
  - Request read at req_addr 0x45 (offset ignored).
  - Expected: mem_addr steps 0x40..0x47 in cycles 1..8, mem_we 0 throughout.
  - resp_valid pulses in cycle 10 only, with resp_data word k = 0xA0+k.
- Write-back:
  - Write req_addr 0x108, req_wdata word k = 0xDEAD0000+k.
  - Expected: mem_we = 1 with mem_addr 0x108..0x10F in cycles 1..8; resp_valid in cycle 9; RAM readback matches.
- Back-to-back with ignored request:
  - Hold req_valid high with a read, then a write.
  - Expected: the second request is accepted only in the first cycle after RESP; req_ready = 0 throughout the first burst; no extra responses.
- Top-of-memory block: read at req_addr 0x3FFFFFFF -> addresses 0x3FFFFFF8..0x3FFFFFFF, no wrap to 0.
- Reset mid-write:
  - Assert rst after the 3rd write strobe.
  - Expected: mem_we drops the same cycle; no resp_valid; only words 0..2 modified in RAM; next request after release behaves normally.

Source files
------------

// File: rtl/cache_fill_server_if.sv
// Block-level request/response bundle between the block cache and cache_fill_server.
// The cache drives through the master modport and the server answers through the slave modport.
interface cache_fill_server_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 30,
    parameter int BLOCK_SIZE    = 3
);
    localparam int JUST_DATA = DATA_WIDTH * (2 ** BLOCK_SIZE);

    logic                     req_valid;
    logic                     req_ready;
    logic                     req_write;
    logic [ADDRESS_WIDTH-1:0] req_addr;
    logic [JUST_DATA-1:0]     req_wdata;
    logic                     resp_valid;
    logic [JUST_DATA-1:0]     resp_data;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/cache_fill_server.sv
// Serves whole-block fills and write-backs as bursts of single-word accesses on a
// synchronous-read word RAM; one block request in, one block response out.
module cache_fill_server #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 30,
    parameter int BLOCK_SIZE    = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    cache_fill_server_if.slave       blk_io,
    output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
    output logic                     mem_we_o,
    output logic [DATA_WIDTH-1:0]    mem_wr_data_o,
    input  logic [DATA_WIDTH-1:0]    mem_rd_data_i
);
    localparam int S         = 2 ** BLOCK_SIZE;
    localparam int JUST_DATA = DATA_WIDTH * S;
    localparam int CNT_W     = BLOCK_SIZE + 1;
    localparam int TAG_W     = ADDRESS_WIDTH - BLOCK_SIZE;
    localparam logic [CNT_W-1:0] CNT_DRAIN = CNT_W'(S);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(S - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [TAG_W-1:0]        tag_q, tag_d;
    logic [JUST_DATA-1:0]    wdata_q, wdata_d;
    logic [JUST_DATA-1:0]    resp_data_q, resp_data_d;
    logic [BLOCK_SIZE-1:0]   cap_idx_s;
    logic                    req_ready_s;
    logic                    resp_valid_s;
    logic                    mem_we_s;
    logic [ADDRESS_WIDTH-1:0] mem_addr_s;
    logic [DATA_WIDTH-1:0]   mem_wr_data_s;

    // The word arriving now was addressed one cycle earlier; the drain count wraps to word S-1.
    assign cap_idx_s = cnt_q[BLOCK_SIZE-1:0] - BLOCK_SIZE'(1'b1);

    // State, burst counter and block registers; reset aborts any burst immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            tag_q       <= '0;
            wdata_q     <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tag_q       <= tag_d;
            wdata_q     <= wdata_d;
            resp_data_q <= resp_data_d;
        end
    end

    // Next-state, counter and block-data update.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tag_d       = tag_q;
        wdata_d     = wdata_q;
        resp_data_d = resp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (blk_io.req_valid && req_ready_s) begin
                    tag_d = blk_io.req_addr[ADDRESS_WIDTH-1:BLOCK_SIZE];
                    cnt_d = '0;
                    if (blk_io.req_write) begin
                        wdata_d = blk_io.req_wdata;
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (cnt_q != '0) begin
                    resp_data_d[int'(cap_idx_s)*DATA_WIDTH +: DATA_WIDTH] = mem_rd_data_i;
                end else begin
                    resp_data_d = resp_data_q;
                end
                if (cnt_q == CNT_DRAIN) begin
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1'b1);
                end
            end
            ST_WRITE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    resp_data_d = wdata_q;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d       = cnt_q + CNT_W'(1'b1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decoded from registered state and counter only.
    always_comb begin
        req_ready_s   = 1'b0;
        resp_valid_s  = 1'b0;
        mem_addr_s    = '0;
        mem_we_s      = 1'b0;
        mem_wr_data_s = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready_s = 1'b1;
            end
            ST_READ: begin
                if (cnt_q != CNT_DRAIN) begin
                    mem_addr_s = {tag_q, cnt_q[BLOCK_SIZE-1:0]};
                end else begin
                    mem_addr_s = '0;
                end
            end
            ST_WRITE: begin
                mem_we_s      = 1'b1;
                mem_addr_s    = {tag_q, cnt_q[BLOCK_SIZE-1:0]};
                mem_wr_data_s = wdata_q[int'(cnt_q[BLOCK_SIZE-1:0])*DATA_WIDTH +: DATA_WIDTH];
            end
            ST_RESP: begin
                resp_valid_s = 1'b1;
            end
            default: begin
                req_ready_s = 1'b0;
            end
        endcase
    end

    assign blk_io.req_ready  = req_ready_s;
    assign blk_io.resp_valid = resp_valid_s;
    assign blk_io.resp_data  = resp_data_q;
    assign mem_addr_o        = mem_addr_s;
    assign mem_we_o          = mem_we_s;
    assign mem_wr_data_o     = mem_wr_data_s;
endmodule

// File: tb/tb_cache_fill_server.sv
// Self-checking bench for cache_fill_server: table vectors, hand-written corner sequences
// and random block traffic against a word-array memory model.
module tb_cache_fill_server;
    localparam int DW = 32;
    localparam int AW = 30;
    localparam int BS = 3;
    localparam int S  = 8;
    localparam int JD = DW * S;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [JD-1:0] wdata;
    } req_t;

    typedef struct {
        req_t          rq;
        logic [AW-1:0] exp_base;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wr_data;
    logic [DW-1:0] mem_rd_data;
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    bit [DW-1:0] ram [0:1023];
    bit [DW-1:0] model_mem [0:1023];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int resp_cnt = 0;

    cache_fill_server_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .BLOCK_SIZE(BS)) blk ();

    cache_fill_server #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .BLOCK_SIZE(BS)) dut (
        .clk           (clk),
        .rst           (rst),
        .blk_io        (blk.slave),
        .mem_addr_o    (mem_addr),
        .mem_we_o      (mem_we),
        .mem_wr_data_o (mem_wr_data),
        .mem_rd_data_i (mem_rd_data)
    );

    always #5 clk = ~clk;

    // Word RAM with synchronous read; low 10 address bits select the word.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[9:0]] <= mem_wr_data;
        else if (pre_we) ram[pre_addr[9:0]] <= pre_data;
        mem_rd_data <= ram[mem_addr[9:0]];
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (blk.resp_valid) resp_cnt <= resp_cnt + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [JD-1:0] act, input logic [JD-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        model_mem[a[9:0]] = d;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    function automatic logic [JD-1:0] model_block(input logic [AW-1:0] base);
        logic [JD-1:0] v;
        logic [AW-1:0] a;
        v = '0;
        for (int k = 0; k < S; k++) begin
            a = base + AW'(k);
            v[k*DW +: DW] = model_mem[a[9:0]];
        end
        return v;
    endfunction

    // One block transaction checked cycle by cycle from the accept edge; called at a negedge.
    task automatic run_req(input req_t r, input logic [AW-1:0] exp_base, input bit chain,
                           input req_t nxt, output int acc);
        logic [JD-1:0] exp_data;
        logic [AW-1:0] a;
        int n;
        blk.req_valid = 1'b1;
        blk.req_write = r.wr;
        blk.req_addr  = r.addr;
        blk.req_wdata = r.wdata;
        n = 0;
        while (!blk.req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", JD'(n < 40), JD'(1));
        @(posedge clk);
        #1;
        acc = cyc;
        if (chain) begin
            blk.req_write = nxt.wr;
            blk.req_addr  = nxt.addr;
            blk.req_wdata = nxt.wdata;
        end else begin
            blk.req_valid = 1'b0;
        end
        if (r.wr) begin
            exp_data = r.wdata;
            for (int k = 0; k < S; k++) begin
                a = exp_base + AW'(k);
                model_mem[a[9:0]] = r.wdata[k*DW +: DW];
            end
        end else begin
            exp_data = model_block(exp_base);
        end
        for (int c = 1; c <= S; c++) begin
            @(negedge clk);
            chk("issue_addr", JD'(mem_addr), JD'(exp_base + AW'(c - 1)));
            chk("issue_we", JD'(mem_we), JD'(r.wr));
            if (r.wr) chk("issue_wdata", JD'(mem_wr_data), JD'(r.wdata[(c-1)*DW +: DW]));
            chk("busy_ready", JD'(blk.req_ready), JD'(0));
            chk("busy_resp", JD'(blk.resp_valid), JD'(0));
        end
        if (!r.wr) begin
            @(negedge clk);
            chk("drain_addr", JD'(mem_addr), JD'(0));
            chk("drain_we", JD'(mem_we), JD'(0));
            chk("drain_resp", JD'(blk.resp_valid), JD'(0));
        end
        @(negedge clk);
        chk("resp_valid", JD'(blk.resp_valid), JD'(1));
        chk("resp_data", blk.resp_data, exp_data);
        chk("resp_ready", JD'(blk.req_ready), JD'(0));
        chk("resp_we", JD'(mem_we), JD'(0));
        @(negedge clk);
        chk("post_resp_valid", JD'(blk.resp_valid), JD'(0));
        chk("post_ready", JD'(blk.req_ready), JD'(1));
        chk("post_data_held", blk.resp_data, exp_data);
    endtask

    initial begin
        req_t          r;
        req_t          nxt;
        req_t          none;
        vec_t          vecs [5];
        logic [JD-1:0] wd;
        logic [AW-1:0] b;
        logic [DW-1:0] ev;
        int            a1;
        int            a2;
        int            rc;

        none = '{wr: 1'b0, addr: '0, wdata: '0};
        blk.req_valid = 1'b0;
        blk.req_write = 1'b0;
        blk.req_addr  = '0;
        blk.req_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", JD'(blk.req_ready), JD'(1));
        chk("rst_resp_valid", JD'(blk.resp_valid), JD'(0));
        chk("rst_resp_data", blk.resp_data, JD'(0));
        chk("rst_mem_addr", JD'(mem_addr), JD'(0));
        chk("rst_mem_we", JD'(mem_we), JD'(0));
        chk("rst_mem_wr_data", JD'(mem_wr_data), JD'(0));

        for (int k = 0; k < S; k++) poke(AW'(32'h40 + k), DW'(32'hA0 + k));
        for (int k = 0; k < S; k++) poke(AW'(32'h3FFFFFF8 + k), DW'(32'h7000_0000 + k));

        for (int k = 0; k < S; k++) wd[k*DW +: DW] = DW'(32'hDEAD_0000 + k);
        vecs[0] = '{rq: '{wr: 1'b0, addr: 30'h45,       wdata: '0}, exp_base: 30'h40};
        vecs[1] = '{rq: '{wr: 1'b1, addr: 30'h108,      wdata: wd}, exp_base: 30'h108};
        vecs[2] = '{rq: '{wr: 1'b0, addr: 30'h3FFFFFFF, wdata: '0}, exp_base: 30'h3FFFFFF8};
        vecs[3] = '{rq: '{wr: 1'b0, addr: 30'h10F,      wdata: '0}, exp_base: 30'h108};
        vecs[4] = '{rq: '{wr: 1'b1, addr: 30'h7,        wdata: ~wd}, exp_base: 30'h0};
        for (int i = 0; i < 5; i++) begin
            run_req(vecs[i].rq, vecs[i].exp_base, 1'b0, none, a1);
            if (vecs[i].rq.wr) begin
                for (int k = 0; k < S; k++) begin
                    b = vecs[i].exp_base + AW'(k);
                    chk("vec_ram_readback", JD'(ram[b[9:0]]), JD'(vecs[i].rq.wdata[k*DW +: DW]));
                end
            end
        end

        // Second request held pending through a whole read burst.
        for (int k = 0; k < S; k++) wd[k*DW +: DW] = $urandom;
        r   = '{wr: 1'b0, addr: 30'h41,  wdata: '0};
        nxt = '{wr: 1'b1, addr: 30'h1C3, wdata: wd};
        rc  = resp_cnt;
        run_req(r, 30'h40, 1'b1, nxt, a1);
        run_req(nxt, 30'h1C0, 1'b0, none, a2);
        chk("b2b_spacing", JD'(a2 - a1), JD'(S + 3));
        @(negedge clk);
        chk("b2b_resp_count", JD'(resp_cnt - rc), JD'(2));

        // Reset after the third write strobe of a write-back.
        for (int k = 0; k < S; k++) poke(AW'(32'h180 + k), DW'(32'h5500_0000 + k));
        for (int k = 0; k < S; k++) wd[k*DW +: DW] = DW'(32'hC0DE_0000 + k);
        chk("mw_ready", JD'(blk.req_ready), JD'(1));
        blk.req_valid = 1'b1;
        blk.req_write = 1'b1;
        blk.req_addr  = 30'h183;
        blk.req_wdata = wd;
        @(posedge clk);
        #1;
        blk.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("mw_we_before", JD'(mem_we), JD'(1));
        rst = 1'b1;
        #1;
        chk("mw_we_drop", JD'(mem_we), JD'(0));
        chk("mw_addr_zero", JD'(mem_addr), JD'(0));
        chk("mw_wdata_zero", JD'(mem_wr_data), JD'(0));
        chk("mw_resp_valid", JD'(blk.resp_valid), JD'(0));
        chk("mw_resp_data", blk.resp_data, JD'(0));
        chk("mw_ready_rst", JD'(blk.req_ready), JD'(1));
        rc = resp_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mw_no_resp", JD'(resp_cnt - rc), JD'(0));
        for (int k = 0; k < S; k++) begin
            ev = (k < 3) ? wd[k*DW +: DW] : DW'(32'h5500_0000 + k);
            chk("mw_ram", JD'(ram[10'(32'h180 + k)]), JD'(ev));
            model_mem[10'(32'h180 + k)] = ev;
        end
        r = '{wr: 1'b0, addr: 30'h180, wdata: '0};
        run_req(r, 30'h180, 1'b0, none, a1);

        // Random block traffic in a small region so fills see earlier write-backs.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            r.wr   = 1'($urandom_range(0, 1));
            r.addr = AW'($urandom_range(0, 511));
            for (int k = 0; k < S; k++) r.wdata[k*DW +: DW] = $urandom;
            b = r.addr - AW'(r.addr % AW'(S));
            run_req(r, b, 1'b0, none, a1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
